mrd_pingpong_sched: RTL
=======================

Name: mrd_pingpong_sched

Overview:
- Packet-level scheduler that shares two mrd_mem_top_v2_p4 instances (mem0, mem1) between one input stream and one output stream.
- Dispatches each input packet to the two memories in strict alternation, so a packet can sink while the other memory runs its Rd/Wr stages.
- Grants the Source phase in dispatch order, so output packets leave in arrival order.
- Sits between the input framing logic and the two memory tops; drives their valid/sop gating and source enables.

Parameters:
- OVERTIME_CYC, 4096, cycles without in_valid inside a packet before the dispatch is aborted.
- wCNT, 16, width of the packet statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_sop  in  1  first beat of an input packet (qualified by in_valid)
- in_eop  in  1  last beat of an input packet (qualified by in_valid)
- in_valid  in  1  input beat valid
- in_ready  out  1  scheduler can accept a new sop
- mem_sink_ready  in  2  sink_ready from mem0/mem1
- mem_valid  out  2  per-memory in_data.valid gating
- mem_sop  out  2  per-memory in_data.sop gating
- src_grant  out  2  one-hot, enables Source phase of mem k
- src_sop  in  2  output sop from mem k
- src_eop  in  2  output eop from mem k
- out_sel  out  1  output mux select (memory index currently sourcing)
- abort  out  2  one-cycle pulse, dispatch to mem k aborted by watchdog
- err_sop  out  1  one-cycle pulse, sop received while not ready or mid-packet
- pkt_in_cnt  out  wCNT  packets fully dispatched (eop seen)
- pkt_out_cnt  out  wCNT  packets fully sourced (src_eop seen)

Behaviour:
- Reset (async, rst_n low): in_ready=0, mem_valid=0, mem_sop=0, src_grant=0, out_sel=0, abort=0, err_sop=0, both counters=0, wr_ptr=0, rd_ptr=0, outstanding=0, FSM=IDLE.
- Dispatch FSM states: IDLE and ROUTE.
  - IDLE: registered in_ready = mem_sink_ready[wr_ptr] & (outstanding<2).
    - in_sop&in_valid&in_ready -> ROUTE, tgt<=wr_ptr, mem_sop[wr_ptr] asserted in the same cycle.
  - ROUTE: mem_valid[tgt]=in_valid and mem_sop=0 (combinational, zero latency); in_ready=0.
    - in_eop&in_valid -> IDLE; wr_ptr<=~wr_ptr; outstanding+1; pkt_in_cnt+1 (wraps).
- Routing is combinational from registered state: mem_valid[k]=in_valid & (state==ROUTE|sop accepted) & tgt==k. The non-target memory always sees 0.
- Single-beat packet (sop&eop in the same beat): accepted, FSM stays IDLE, counters and wr_ptr update as on eop.
- Watchdog:
  - Counter clears on every in_valid in ROUTE.
  - On reaching OVERTIME_CYC-1 without in_valid: abort[tgt] pulses, FSM->IDLE.
  - On abort, wr_ptr, outstanding and pkt_in_cnt are unchanged; the aborted memory self-returns to Idle.
- err_sop pulses for in_sop&in_valid while in ROUTE, or in IDLE with in_ready=0. The beat is dropped (no mem_valid).
- Source sequencing: src_grant[rd_ptr]=1 while outstanding>0; out_sel=rd_ptr.
  - On src_eop[rd_ptr]: grant drops the next cycle, rd_ptr toggles, outstanding-1, pkt_out_cnt+1.
  - src_sop/src_eop from the non-granted memory are ignored.
- Simultaneous eop dispatch and src_eop in one cycle: outstanding unchanged (+1-1); both pointers toggle.
- outstanding saturates at 2; in_ready=0 while outstanding=2, so the input is back-pressured until a source completes.

Decomposition:
- Shared package mrd_sched_pkg: FSM enum {IDLE, ROUTE}, constant N_MEM=2, counter width default.
- Natural sub-module: mrd_sched_watchdog (load/clear/expire counter, parameterised OVERTIME_CYC).
- Everything else stays in the top.

Test Plan:
- Two back-to-back 12-beat packets, both sink_ready=1 -> packet A on mem_valid[0], packet B on mem_valid[1]; pkt_in_cnt=2, outstanding=2, in_ready=0.
- Third sop while outstanding=2 -> err_sop pulse, no mem_valid. After src_eop[0]: src_grant moves 01->10, in_ready returns to 1 next cycle.
- Packet to mem0 stalls (in_valid=0) for OVERTIME_CYC=16 cycles -> abort[0] pulse at cycle 16, FSM IDLE, wr_ptr still 0, pkt_in_cnt unchanged.
- src_eop[1] pulsed while rd_ptr=0 -> ignored: pkt_out_cnt unchanged, out_sel stays 0.
- Dispatch eop and src_eop[rd_ptr] in the same cycle with outstanding=1 -> outstanding stays 1; wr_ptr and rd_ptr both toggle.
- rst_n asserted mid-ROUTE (beat 5 of 12) -> all outputs take reset values immediately (async); next sop goes to mem0.

Source files
------------

// File: rtl/mrd_sched_pkg.sv
// Shared types and constants for the two-memory ping-pong packet scheduler.
package mrd_sched_pkg;

  localparam int N_MEM        = 2;
  localparam int CNT_W_DEF    = 16;
  localparam int OVERTIME_DEF = 4096;

  // Dispatch side: waiting for a sop, or steering beats of an open packet.
  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } sched_state_e;

  // One-hot select of a memory from its index.
  function automatic logic [N_MEM-1:0] mem_onehot(input logic idx);
    logic [N_MEM-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mrd_sched_watchdog.sv
// Stall watchdog for an open dispatch: counts consecutive cycles without a
// beat and flags expiry on the OVERTIME_CYC-th such cycle.
module mrd_sched_watchdog #(
  parameter int OVERTIME_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,  // a packet is open
  input  logic clear,   // a beat arrived this cycle
  output logic expire
);

  localparam int CW = (OVERTIME_CYC > 2) ? $clog2(OVERTIME_CYC) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(OVERTIME_CYC - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // Expiry is only meaningful while a packet is open and no beat is present.
  assign expire = enable & ~clear & (cnt_reg == LIMIT);

  // Count idle cycles; restart on any beat, when idle, or after expiry.
  always_comb begin
    cnt_next = cnt_reg + CW'(1);
    if (!enable || clear || expire) begin
      cnt_next = '0;
    end
  end

  // Idle-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/mrd_pingpong_sched.sv
// Ping-pong scheduler sharing two memory tops between one input and one
// output stream: packets alternate mem0/mem1 on the way in and are sourced
// back in the same order on the way out.
module mrd_pingpong_sched
  import mrd_sched_pkg::*;
#(
  parameter int OVERTIME_CYC = OVERTIME_DEF,
  parameter int wCNT         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_MEM-1:0] mem_sink_ready,
  output logic [N_MEM-1:0] mem_valid,
  output logic [N_MEM-1:0] mem_sop,
  output logic [N_MEM-1:0] src_grant,
  input  logic [N_MEM-1:0] src_sop,
  input  logic [N_MEM-1:0] src_eop,
  output logic             out_sel,
  output logic [N_MEM-1:0] abort,
  output logic             err_sop,
  output logic [wCNT-1:0]  pkt_in_cnt,
  output logic [wCNT-1:0]  pkt_out_cnt
);

  sched_state_e    state_reg, state_next;
  logic            wr_ptr_reg, wr_ptr_next;
  logic            rd_ptr_reg, rd_ptr_next;
  logic            tgt_reg, tgt_next;
  logic [1:0]      outst_reg, outst_next;
  logic            in_ready_reg, in_ready_next;
  logic            err_sop_reg, err_sop_next;
  logic [wCNT-1:0] pkt_in_cnt_reg, pkt_in_cnt_next;
  logic [wCNT-1:0] pkt_out_cnt_reg, pkt_out_cnt_next;

  logic sop_beat;
  logic sop_acc;
  logic route_beat;
  logic route_en;
  logic route_sel;
  logic disp_done;
  logic src_busy;
  logic src_done;
  logic wd_expire;

  // Sequencing keys off eop only; the memories' sop carries no scheduling info.
  logic unused_src_sop;
  assign unused_src_sop = ^src_sop;

  // A sop is taken only in IDLE with in_ready high; any other sop is dropped.
  assign sop_beat   = in_valid & in_sop;
  assign sop_acc    = (state_reg == IDLE) & sop_beat & in_ready_reg;
  // Mid-packet beats; a stray sop inside a packet is not forwarded.
  assign route_beat = (state_reg == ROUTE) & in_valid & ~in_sop;
  assign route_en   = sop_acc | route_beat;
  // On the sop beat the target register is not loaded yet, so use wr_ptr.
  assign route_sel  = sop_acc ? wr_ptr_reg : tgt_reg;
  // Covers both a normal eop and a single-beat (sop+eop) packet.
  assign disp_done  = route_en & in_eop;

  // Only the memory currently granted may complete a source phase.
  assign src_busy   = (outst_reg != 2'd0);
  assign src_done   = src_busy & src_eop[rd_ptr_reg];

  mrd_sched_watchdog #(
    .OVERTIME_CYC (OVERTIME_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_reg == ROUTE),
    .clear  (in_valid),
    .expire (wd_expire)
  );

  // Dispatch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Dispatch FSM next state: open on a multi-beat sop, close on eop or stall.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (sop_acc && !in_eop) begin
          state_next = ROUTE;
        end
      end
      ROUTE: begin
        if ((route_beat && in_eop) || wd_expire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Dispatch FSM outputs: per-memory beat gating, sop marker and abort pulse.
  always_comb begin
    mem_valid = '0;
    mem_sop   = '0;
    abort     = '0;
    if (route_en) begin
      mem_valid = mem_onehot(route_sel);
    end
    if (sop_acc) begin
      mem_sop = mem_onehot(wr_ptr_reg);
    end
    if (wd_expire) begin
      abort = mem_onehot(tgt_reg);
    end
  end

  // Pointer, occupancy, counter and handshake next values.
  always_comb begin
    tgt_next         = sop_acc ? wr_ptr_reg : tgt_reg;
    wr_ptr_next      = disp_done ? ~wr_ptr_reg : wr_ptr_reg;
    rd_ptr_next      = src_done ? ~rd_ptr_reg : rd_ptr_reg;
    pkt_in_cnt_next  = pkt_in_cnt_reg + wCNT'(disp_done);
    pkt_out_cnt_next = pkt_out_cnt_reg + wCNT'(src_done);

    // Dispatch and source completing together leave occupancy unchanged.
    outst_next = outst_reg;
    if (disp_done && !src_done && (outst_reg != 2'd2)) begin
      outst_next = outst_reg + 2'd1;
    end else if (!disp_done && src_done) begin
      outst_next = outst_reg - 2'd1;
    end

    // Ready for the next sop when idle, the next memory can sink, and a slot is free.
    in_ready_next = (state_next == IDLE) & mem_sink_ready[wr_ptr_next] &
                    (outst_next != 2'd2);
    err_sop_next  = sop_beat & ((state_reg == ROUTE) | ~in_ready_reg);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_reg         <= 1'b0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      outst_reg       <= 2'd0;
      in_ready_reg    <= 1'b0;
      err_sop_reg     <= 1'b0;
      pkt_in_cnt_reg  <= '0;
      pkt_out_cnt_reg <= '0;
    end else begin
      tgt_reg         <= tgt_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      outst_reg       <= outst_next;
      in_ready_reg    <= in_ready_next;
      err_sop_reg     <= err_sop_next;
      pkt_in_cnt_reg  <= pkt_in_cnt_next;
      pkt_out_cnt_reg <= pkt_out_cnt_next;
    end
  end

  // Source grant follows the read pointer while any packet is outstanding.
  for (genvar gi = 0; gi < N_MEM; gi++) begin : g_grant
    assign src_grant[gi] = src_busy & (rd_ptr_reg == 1'(gi));
  end

  assign out_sel     = rd_ptr_reg;
  assign in_ready    = in_ready_reg;
  assign err_sop     = err_sop_reg;
  assign pkt_in_cnt  = pkt_in_cnt_reg;
  assign pkt_out_cnt = pkt_out_cnt_reg;

endmodule
